// File: rtl/sfp_mult_rr_sched.sv
// rtl/sfp_mult_rr_sched.sv - round-robin sharing of one pipelined sfp multiplier among N_REQ requesters
// Results carry the requester index; clip_sticky records per-requester saturation since last clear.
module sfp_mult_rr_sched #(
   parameter int N_REQ  = 4,
   parameter int IW_IN  = 2,
   parameter int QW_IN  = 14,
   parameter int IW_OUT = 2,
   parameter int QW_OUT = 14,
   parameter int CLIP   = 1,
   parameter int LAT    = 2,
   localparam int W_IN  = IW_IN + QW_IN,
   localparam int W_OUT = IW_OUT + QW_OUT,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_REQ-1:0]        req_valid_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic [N_REQ*W_IN-1:0]   req_a_i,
   input  logic [N_REQ*W_IN-1:0]   req_b_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [IDW-1:0]          rsp_id_o,
   output logic [W_OUT-1:0]        rsp_data_o,
   output logic                    rsp_clip_o,
   output logic [N_REQ-1:0]        clip_sticky_o,
   input  logic [N_REQ-1:0]        clip_clr_i
);

   localparam int PW = 2 * W_IN;
   localparam int PQ = 2 * QW_IN;
   localparam int EW = PW + QW_OUT + W_OUT;
   localparam int SW = IDW + 1;

   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [N_REQ-1:0]        grant;
   logic [IDW-1:0]          grant_id;
   logic                    grant_any;
   logic [SW-1:0]           scan_sum;
   logic [IDW-1:0]          scan_id;
   logic                    adv, accept;
   int                      sel_base;
   logic signed [PW-1:0]    op_a, op_b, prod;
   logic signed [EW-1:0]    prod_ext, scaled;
   logic                    ovf;
   logic [W_OUT-1:0]        res_data;
   logic                    res_clip;
   logic [LAT-1:0]          stg_v_q, stg_clip_q;
   logic [IDW-1:0]          stg_id_q   [LAT];
   logic [W_OUT-1:0]        stg_data_q [LAT];
   logic [N_REQ-1:0]        sticky_q, sticky_d, clip_set;

   assign rsp_valid_o   = stg_v_q[LAT-1];
   assign rsp_id_o      = stg_id_q[LAT-1];
   assign rsp_data_o    = stg_data_q[LAT-1];
   assign rsp_clip_o    = stg_clip_q[LAT-1];
   assign clip_sticky_o = sticky_q;

   // Reset also blocks grants so no requester sees a handshake that is then discarded.
   assign adv         = (!rsp_valid_o || rsp_ready_i) && !rst_i;
   assign accept      = adv && grant_any;
   assign req_ready_o = adv ? grant : '0;

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      scan_sum  = '0;
      scan_id   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_sum = {1'b0, ptr_q} + SW'(k);
         if (scan_sum >= SW'(N_REQ)) begin
            scan_sum = scan_sum - SW'(N_REQ);
         end
         scan_id = scan_sum[IDW-1:0];
         if (!grant_any && req_valid_i[scan_id]) begin
            grant_any      = 1'b1;
            grant_id       = scan_id;
            grant[scan_id] = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

   // Scale by 2^QW_OUT before dropping PQ bits so both truncation and zero-fill fall out of one path.
   always_comb begin
      sel_base = int'(grant_id) * W_IN;
      op_a     = {{W_IN{req_a_i[sel_base + W_IN - 1]}}, req_a_i[sel_base +: W_IN]};
      op_b     = {{W_IN{req_b_i[sel_base + W_IN - 1]}}, req_b_i[sel_base +: W_IN]};
      prod     = op_a * op_b;
      prod_ext = {{(EW - PW){prod[PW-1]}}, prod};
      scaled   = (prod_ext <<< QW_OUT) >>> PQ;
      ovf      = !((&scaled[EW-1:W_OUT-1]) || !(|scaled[EW-1:W_OUT-1]));
      res_data = scaled[W_OUT-1:0];
      res_clip = 1'b0;
      if (CLIP != 0 && ovf) begin
         res_clip = 1'b1;
         res_data = scaled[EW-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
      end
   end

   always_comb begin
      clip_set = '0;
      if (rsp_valid_o && rsp_ready_i && rsp_clip_o) begin
         clip_set[rsp_id_o] = 1'b1;
      end
      sticky_d = (sticky_q & ~clip_clr_i) | clip_set;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q      <= '0;
         sticky_q   <= '0;
         stg_v_q    <= '0;
         stg_clip_q <= '0;
         for (int k = 0; k < LAT; k++) begin
            stg_id_q[k]   <= '0;
            stg_data_q[k] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         sticky_q <= sticky_d;
         if (adv) begin
            stg_v_q[0]    <= accept;
            stg_id_q[0]   <= grant_id;
            stg_data_q[0] <= res_data;
            stg_clip_q[0] <= res_clip;
            for (int k = 1; k < LAT; k++) begin
               stg_v_q[k]    <= stg_v_q[k-1];
               stg_id_q[k]   <= stg_id_q[k-1];
               stg_data_q[k] <= stg_data_q[k-1];
               stg_clip_q[k] <= stg_clip_q[k-1];
            end
         end
      end
   end

endmodule
